// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed seven-segment driver with frame-synchronous
// display update, dead-time between digit slots and optional leading-zero blanking.
module seven_seg_scan #(
   parameter int DIGITS      = 2,
   parameter int HEX_EN      = 1,
   parameter int REFRESH_DIV = 1000,
   parameter int DEAD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic [6:0]            seg_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_start
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [6:0] GLYPH_ERR = 7'b1001001;

   logic [CNT_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] display;
   logic [4*DIGITS-1:0] pending;
   logic                pending_valid;
   logic                slot_end;
   logic                wrap;
   logic [3:0]          cur_nib;
   logic                cur_blank;
   logic                upper_zero;
   logic [6:0]          glyph;

   assign slot_end = (div_cnt == CNT_W'(REFRESH_DIV - 1));
   assign wrap     = slot_end && (idx == IDX_W'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt       <= '0;
         idx           <= '0;
         display       <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
      end else begin
         if (slot_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (load)
            pending <= value_in;

         // The display only ever changes on the frame wrap, so a frame never tears.
         if (wrap) begin
            pending_valid <= 1'b0;
            if (load)
               display <= value_in;
            else if (pending_valid)
               display <= pending;
         end else if (load) begin
            pending_valid <= 1'b1;
         end
      end
   end

   // Walk from the most significant digit down, tracking whether everything above is zero.
   always_comb begin
      cur_nib    = 4'd0;
      cur_blank  = 1'b0;
      upper_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero && (display[4*k +: 4] == 4'd0);
         if (idx == IDX_W'(k)) begin
            cur_nib   = display[4*k +: 4];
            cur_blank = blank_lz && upper_zero && (k != 0);
         end
      end
   end

   always_comb begin
      glyph = GLYPH_ERR;
      case (cur_nib)
         4'h0: glyph = 7'b0111111;
         4'h1: glyph = 7'b0000110;
         4'h2: glyph = 7'b1011011;
         4'h3: glyph = 7'b1001111;
         4'h4: glyph = 7'b1100110;
         4'h5: glyph = 7'b1101101;
         4'h6: glyph = 7'b1111101;
         4'h7: glyph = 7'b0000111;
         4'h8: glyph = 7'b1111111;
         4'h9: glyph = 7'b1101111;
         4'hA: glyph = (HEX_EN != 0) ? 7'b1110111 : GLYPH_ERR;
         4'hB: glyph = (HEX_EN != 0) ? 7'b1111100 : GLYPH_ERR;
         4'hC: glyph = (HEX_EN != 0) ? 7'b0111001 : GLYPH_ERR;
         4'hD: glyph = (HEX_EN != 0) ? 7'b1011110 : GLYPH_ERR;
         4'hE: glyph = (HEX_EN != 0) ? 7'b1111001 : GLYPH_ERR;
         4'hF: glyph = (HEX_EN != 0) ? 7'b1110001 : GLYPH_ERR;
         default: glyph = GLYPH_ERR;
      endcase
      if (cur_blank)
         glyph = 7'b0000000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_out     <= 7'h7F;
         dig_sel     <= '1;
         frame_start <= 1'b0;
      end else begin
         seg_out     <= ~glyph;
         dig_sel     <= (div_cnt >= CNT_W'(DEAD_CYCLES)) ? ~(DIGITS'(1) << idx) : '1;
         frame_start <= (div_cnt == '0) && (idx == '0);
      end
   end

endmodule
